// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life plot path: grid geometry
// defaults, the two display colours and the plot arbiter state set.
package life_pkg;

    localparam int GRID_W_DEF    = 4;
    localparam int GRID_H_DEF    = 4;
    localparam int CELL_SIZE_DEF = 4;

    localparam logic [2:0] COLOUR_BG   = 3'b000;
    localparam logic [2:0] COLOUR_LIVE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PAINT_LOAD,
        ST_PAINT_SIM,
        ST_SIM_WAIT
    } state_e;

    // True when a cell coordinate lies inside a w x h grid.
    function automatic logic cell_in_grid(input logic [7:0] x, input logic [7:0] y,
                                          input int w, input int h);
        return (int'(x) < w) && (int'(y) < h);
    endfunction

endpackage

// File: rtl/life_cell_painter.sv
// Pixel walker for the plot arbiter. Produces one pixel address per step
// in raster order (px fastest). In cell mode it walks a CELL_SIZE square
// at (x*CELL_SIZE, y*CELL_SIZE); in sweep mode it walks the whole grid.
// The pixel presented while start_i is high is the first pixel of the new
// walk, so the caller can register it on the very edge that starts it.
module life_cell_painter
    import life_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int CELL_SIZE = CELL_SIZE_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic       sweep_i,
    input  logic       step_i,
    input  logic [7:0] cell_x_i,
    input  logic [7:0] cell_y_i,
    output logic [7:0] pix_x_o,
    output logic [7:0] pix_y_o,
    output logic       done_o
);

    localparam logic [7:0] SWEEP_LIM_X = 8'(GRID_W * CELL_SIZE - 1);
    localparam logic [7:0] SWEEP_LIM_Y = 8'(GRID_H * CELL_SIZE - 1);
    localparam logic [7:0] CELL_LIM    = 8'(CELL_SIZE - 1);

    logic [7:0] base_x_q, base_x_d, base_y_q, base_y_d;
    logic [7:0] lim_x_q, lim_x_d, lim_y_q, lim_y_d;
    logic [7:0] px_q, px_d, py_q, py_d;
    logic       done_q, done_d;

    logic [7:0] eff_base_x, eff_base_y, eff_lim_x, eff_lim_y, eff_px, eff_py;
    logic       eff_last;

    // Select the walk being emitted this cycle (fresh start or in progress)
    // and work out where the walk goes after this pixel.
    always_comb begin
        if (start_i) begin
            eff_base_x = sweep_i ? 8'd0 : 8'(int'(cell_x_i) * CELL_SIZE);
            eff_base_y = sweep_i ? 8'd0 : 8'(int'(cell_y_i) * CELL_SIZE);
            eff_lim_x  = sweep_i ? SWEEP_LIM_X : CELL_LIM;
            eff_lim_y  = sweep_i ? SWEEP_LIM_Y : CELL_LIM;
            eff_px     = 8'd0;
            eff_py     = 8'd0;
        end else begin
            eff_base_x = base_x_q;
            eff_base_y = base_y_q;
            eff_lim_x  = lim_x_q;
            eff_lim_y  = lim_y_q;
            eff_px     = px_q;
            eff_py     = py_q;
        end
        eff_last = (eff_px == eff_lim_x) && (eff_py == eff_lim_y);

        base_x_d = eff_base_x;
        base_y_d = eff_base_y;
        lim_x_d  = eff_lim_x;
        lim_y_d  = eff_lim_y;
        px_d     = eff_px;
        py_d     = eff_py;
        done_d   = done_q & ~start_i;
        if (start_i || step_i) begin
            if (eff_last) begin
                done_d = 1'b1;
            end else if (eff_px == eff_lim_x) begin
                px_d = 8'd0;
                py_d = eff_py + 8'd1;
            end else begin
                px_d = eff_px + 8'd1;
            end
        end
    end

    assign pix_x_o = eff_base_x + eff_px;
    assign pix_y_o = eff_base_y + eff_py;
    assign done_o  = done_q & ~start_i;

    // Walk state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_x_q <= 8'd0;
            base_y_q <= 8'd0;
            lim_x_q  <= 8'd0;
            lim_y_q  <= 8'd0;
            px_q     <= 8'd0;
            py_q     <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            lim_x_q  <= lim_x_d;
            lim_y_q  <= lim_y_d;
            px_q     <= px_d;
            py_q     <= py_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: rtl/life_plot_arbiter.sv
// Sole owner of the VGA plot port. Arbitrates between the clear sweep,
// user cell loads and the simulation change stream, expanding each cell
// into a CELL_SIZE x CELL_SIZE block plotted one pixel per clock.
module life_plot_arbiter
    import life_pkg::*;
#(
    parameter int GRID_W         = GRID_W_DEF,
    parameter int GRID_H         = GRID_H_DEF,
    parameter int CELL_SIZE      = CELL_SIZE_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear_req,
    output logic       clear_busy,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_x,
    input  logic [7:0] load_y,
    input  logic [2:0] load_colour,
    input  logic       sim_valid,
    output logic       sim_ready,
    input  logic [7:0] sim_x,
    input  logic [7:0] sim_y,
    input  logic [2:0] sim_colour,
    input  logic       sim_last,
    output logic       gen_done,
    output logic       range_err,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    if (GRID_W * CELL_SIZE > 256 || GRID_H * CELL_SIZE > 256) begin : g_span_check
        $error("life_plot_arbiter: grid pixel span exceeds 8-bit VGA coordinates");
    end
    if (CELL_SIZE < 1 || CELL_SIZE > 16 || (CELL_SIZE & (CELL_SIZE - 1)) != 0) begin : g_cell_check
        $error("life_plot_arbiter: CELL_SIZE must be a power of 2 in 1..16");
    end

    state_e     state_q;
    logic       clear_pend_q, clear_pend_d;
    logic [2:0] colour_q;
    logic       last_q;
    logic [7:0] vga_x_q, vga_y_q;
    logic [2:0] vga_colour_q;
    logic       vga_plot_q, gen_done_q, range_err_q;

    logic       is_idle, is_wait, painting;
    logic       load_fire, sim_fire;
    logic [7:0] sel_x, sel_y;
    logic [2:0] sel_colour, emit_colour;
    logic       sel_in_grid, start_clear, cell_start;
    logic       paint_start, paint_step, emit, sweep_end;
    logic [7:0] pix_x, pix_y;
    logic       painter_done;
    state_e     sim_next_st;

    assign is_idle  = (state_q == ST_IDLE);
    assign is_wait  = (state_q == ST_SIM_WAIT);
    assign painting = (state_q == ST_CLEAR) || (state_q == ST_PAINT_LOAD) ||
                      (state_q == ST_PAINT_SIM);

    assign load_ready = is_idle & ~clear_pend_q & ~reset;
    assign sim_ready  = ((is_idle & ~clear_pend_q & ~load_valid) | is_wait) & ~reset;
    assign load_fire  = load_valid & load_ready;
    assign sim_fire   = sim_valid & sim_ready;

    // Route the accepted requester's cell to the painter and the FSM.
    always_comb begin
        sel_x      = sim_x;
        sel_y      = sim_y;
        sel_colour = sim_colour;
        if (load_fire) begin
            sel_x      = load_x;
            sel_y      = load_y;
            sel_colour = load_colour;
        end
    end

    assign sel_in_grid = cell_in_grid(sel_x, sel_y, GRID_W, GRID_H);
    assign start_clear = is_idle & clear_pend_q;
    assign cell_start  = (load_fire | sim_fire) & sel_in_grid;
    assign paint_start = start_clear | cell_start;
    assign paint_step  = painting & ~painter_done;
    assign emit        = paint_start | paint_step;
    assign emit_colour = cell_start ? sel_colour : (start_clear ? COLOUR_BG : colour_q);
    assign sweep_end   = (state_q == ST_CLEAR) & painter_done;

    // A request arriving in the sweep's final cycle survives the clear-down.
    assign clear_pend_d = clear_req | (clear_pend_q & ~sweep_end);

    // Where an accepted simulation beat sends the FSM; off-grid beats paint nothing.
    always_comb begin
        sim_next_st = ST_PAINT_SIM;
        if (!sel_in_grid) begin
            sim_next_st = sim_last ? ST_IDLE : ST_SIM_WAIT;
        end
    end

    life_cell_painter #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .CELL_SIZE(CELL_SIZE)
    ) u_painter (
        .clock   (clock),
        .reset   (reset),
        .start_i (paint_start),
        .sweep_i (start_clear),
        .step_i  (paint_step),
        .cell_x_i(sel_x),
        .cell_y_i(sel_y),
        .pix_x_o (pix_x),
        .pix_y_o (pix_y),
        .done_o  (painter_done)
    );

    // Arbitration FSM with registered VGA strobe, gen_done pulse and sticky range error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clear_pend_q <= CLEAR_ON_RESET;
            colour_q     <= 3'b000;
            last_q       <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 8'd0;
            vga_colour_q <= 3'b000;
            vga_plot_q   <= 1'b0;
            gen_done_q   <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            clear_pend_q <= clear_pend_d;
            gen_done_q   <= 1'b0;
            vga_plot_q   <= emit;
            if (emit) begin
                vga_x_q      <= pix_x;
                vga_y_q      <= pix_y;
                vga_colour_q <= emit_colour;
            end
            if (load_fire || sim_fire) begin
                colour_q <= sel_colour;
                last_q   <= sim_fire & sim_last;
                if (!sel_in_grid) begin
                    range_err_q <= 1'b1;
                    if (sim_fire && sim_last) begin
                        gen_done_q <= 1'b1;
                    end
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_clear) begin
                        colour_q <= COLOUR_BG;
                        state_q  <= ST_CLEAR;
                    end else if (load_fire) begin
                        state_q <= sel_in_grid ? ST_PAINT_LOAD : ST_IDLE;
                    end else if (sim_fire) begin
                        state_q <= sim_next_st;
                    end
                end
                ST_SIM_WAIT: begin
                    if (sim_fire) begin
                        state_q <= sim_next_st;
                    end
                end
                ST_CLEAR, ST_PAINT_LOAD: begin
                    if (painter_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PAINT_SIM: begin
                    if (painter_done) begin
                        gen_done_q <= last_q;
                        state_q    <= last_q ? ST_IDLE : ST_SIM_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign clear_busy = clear_pend_q | (state_q == ST_CLEAR);
    assign gen_done   = gen_done_q;
    assign range_err  = range_err_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_life_plot_arbiter.sv
// Scoreboard bench for life_plot_arbiter: drivers push the pixels and
// gen_done events each accepted request must produce; a monitor pops and
// compares whenever the DUT plots or pulses gen_done.
module tb_life_plot_arbiter;

    localparam int GW = 4;
    localparam int GH = 4;
    localparam int CS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear_req = 1'b0;
    logic       clear_busy;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_x = 8'd0, load_y = 8'd0;
    logic [2:0] load_colour = 3'd0;
    logic       sim_valid = 1'b0;
    logic       sim_ready;
    logic [7:0] sim_x = 8'd0, sim_y = 8'd0;
    logic [2:0] sim_colour = 3'd0;
    logic       sim_last = 1'b0;
    logic       gen_done, range_err;
    logic [7:0] vga_x, vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    typedef struct {
        bit         isDone;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } expect_t;

    expect_t expQ[$];
    expect_t monItem;
    int      assertCount = 0;
    int      failCount = 0;
    int      cycleCount = 0;
    bit      inGen = 1'b0;
    bit      rangeErrExp = 1'b0;

    life_plot_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_x     (load_x),
        .load_y     (load_y),
        .load_colour(load_colour),
        .sim_valid  (sim_valid),
        .sim_ready  (sim_ready),
        .sim_x      (sim_x),
        .sim_y      (sim_y),
        .sim_colour (sim_colour),
        .sim_last   (sim_last),
        .gen_done   (gen_done),
        .range_err  (range_err),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    // Free-running clock and a cycle counter used to order acceptances.
    always #5 clock = ~clock;
    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Expected output of one accepted cell: a raster-ordered block, or nothing if off-grid.
    task automatic pushCell(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input bit last);
        if (int'(x) < GW && int'(y) < GH) begin
            for (int py = 0; py < CS; py++) begin
                for (int px = 0; px < CS; px++) begin
                    expect_t e;
                    e.isDone = 1'b0;
                    e.x = 8'(int'(x) * CS + px);
                    e.y = 8'(int'(y) * CS + py);
                    e.c = c;
                    expQ.push_back(e);
                end
            end
        end else begin
            rangeErrExp = 1'b1;
        end
        if (last) begin
            expect_t d;
            d.isDone = 1'b1;
            d.x = 8'd0;
            d.y = 8'd0;
            d.c = 3'd0;
            expQ.push_back(d);
        end
    endtask

    // Expected output of a full clear: every grid pixel in colour 0.
    task automatic pushClear();
        for (int y = 0; y < GH * CS; y++) begin
            for (int x = 0; x < GW * CS; x++) begin
                expect_t e;
                e.isDone = 1'b0;
                e.x = 8'(x);
                e.y = 8'(y);
                e.c = 3'd0;
                expQ.push_back(e);
            end
        end
    endtask

    // Drive one request on the load (isSim=0) or sim (isSim=1) port until accepted.
    task automatic applyStimulus(input bit isSim, input logic [7:0] x, input logic [7:0] y,
                                 input logic [2:0] c, input bit last, output int accCycle);
        int budget;
        budget = 3000;
        accCycle = -1;
        @(posedge clock);
        #1;
        if (isSim) begin
            sim_valid = 1'b1; sim_x = x; sim_y = y; sim_colour = c; sim_last = last;
        end else begin
            load_valid = 1'b1; load_x = x; load_y = y; load_colour = c;
        end
        while (budget > 0) begin
            @(negedge clock);
            #1;
            if (isSim ? sim_ready : load_ready) begin
                accCycle = cycleCount;
                pushCell(x, y, c, isSim && last);
                if (isSim) inGen = !last;
                break;
            end
            budget--;
        end
        if (accCycle < 0) begin
            reportFail(isSim ? "sim_accept_timeout" : "load_accept_timeout",
                       $sformatf("ready never seen, got 0, expected 1"));
        end
        @(posedge clock);
        #1;
        if (isSim) sim_valid = 1'b0;
        else load_valid = 1'b0;
    endtask

    // Wait for every expected pixel/event to appear, bounded.
    task automatic waitDrain(input string name);
        int budget;
        budget = expQ.size() * 2 + 200;
        while (expQ.size() != 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (expQ.size() != 0) begin
            reportFail(name, $sformatf("got %0d items still pending, expected 0", expQ.size()));
            expQ.delete();
        end
        repeat (4) @(posedge clock);
    endtask

    task automatic pulseClear();
        @(posedge clock);
        #1 clear_req = 1'b1;
        @(posedge clock);
        #1 clear_req = 1'b0;
    endtask

    // Monitor: compare every plot and gen_done against the scoreboard, and
    // check that no requester is offered the port while a block is still owed.
    always @(negedge clock) begin
        if (!reset) begin
            if (vga_plot) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected_plot", $sformatf("got (%0d,%0d,c%0d), expected none", vga_x, vga_y, vga_colour));
                end else begin
                    monItem = expQ.pop_front();
                    assertCount++;
                    if (monItem.isDone || vga_x !== monItem.x || vga_y !== monItem.y || vga_colour !== monItem.c) begin
                        failCount++;
                        $display("[TB] FAIL plot: got (%0d,%0d,c%0d), expected %s(%0d,%0d,c%0d)", vga_x, vga_y, vga_colour,
                                 monItem.isDone ? "gen_done " : "", monItem.x, monItem.y, monItem.c);
                    end
                end
            end
            if (gen_done) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected_gen_done", "got pulse, expected none");
                end else begin
                    monItem = expQ.pop_front();
                    assertCount++;
                    if (!monItem.isDone) begin
                        failCount++;
                        $display("[TB] FAIL gen_done: got pulse, expected pixel (%0d,%0d,c%0d)", monItem.x, monItem.y, monItem.c);
                    end
                end
            end
            if (load_ready || sim_ready) begin
                checkOutput("ready_while_busy", expQ.size(), 0);
            end
            if (inGen) begin
                checkOutput("load_ready_in_generation", load_ready, 1'b0);
            end
            if (load_valid && !inGen) begin
                checkOutput("sim_ready_vs_load_priority", sim_ready, 1'b0);
            end
        end
    end

    // Absolute watchdog.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int accA, accB, accLast;
    int op, nb;
    bit withLoad;

    initial begin
        // Reset state, then the automatic clear sweep.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_vga_plot", vga_plot, 1'b0);
        checkOutput("reset_gen_done", gen_done, 1'b0);
        checkOutput("reset_range_err", range_err, 1'b0);
        checkOutput("reset_clear_busy", clear_busy, 1'b1);
        checkOutput("reset_load_ready", load_ready, 1'b0);
        checkOutput("reset_sim_ready", sim_ready, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        pushClear();
        waitDrain("reset_clear_drain");
        checkOutput("clear_busy_after_sweep", clear_busy, 1'b0);

        // Single directed load with first-plot latency.
        @(posedge clock);
        #1 load_valid = 1'b1; load_x = 8'd2; load_y = 8'd1; load_colour = 3'b111;
        @(negedge clock);
        #1 checkOutput("load_ready_idle", load_ready, 1'b1);
        pushCell(8'd2, 8'd1, 3'b111, 1'b0);
        @(posedge clock);
        #1 load_valid = 1'b0;
        @(negedge clock);
        #1 checkOutput("first_plot_latency", vga_plot, 1'b1);
        checkOutput("first_plot_x", vga_x, 8'd8);
        checkOutput("first_plot_y", vga_y, 8'd4);
        waitDrain("load_drain");
        checkOutput("idle_after_load", vga_plot, 1'b0);

        // Three-beat generation with a load raised mid-burst.
        fork
            begin
                applyStimulus(1'b1, 8'd1, 8'd1, 3'd7, 1'b0, accA);
                applyStimulus(1'b1, 8'd2, 8'd2, 3'd3, 1'b0, accA);
                applyStimulus(1'b1, 8'd3, 8'd3, 3'd6, 1'b1, accLast);
            end
            begin
                repeat (5) @(posedge clock);
                applyStimulus(1'b0, 8'd0, 8'd3, 3'd2, 1'b0, accB);
            end
        join
        checkOutput("load_after_burst", accB > accLast, 1'b1);
        waitDrain("burst_drain");

        // Load and sim offered in the same cycle: load wins.
        fork
            applyStimulus(1'b0, 8'd3, 8'd0, 3'd5, 1'b0, accA);
            applyStimulus(1'b1, 8'd0, 8'd0, 3'd4, 1'b1, accB);
        join
        checkOutput("load_wins_tie", accA < accB, 1'b1);
        waitDrain("tie_drain");

        // Off-grid sim beat with last: no plot, gen_done still, sticky error.
        applyStimulus(1'b1, 8'd4, 8'd0, 3'd7, 1'b1, accA);
        waitDrain("oor_drain");
        checkOutput("range_err_set", range_err, rangeErrExp);
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd1, 1'b0, accA);
        waitDrain("post_oor_drain");
        checkOutput("range_err_sticky", range_err, 1'b1);

        // Clear request during a sweep is merged into it.
        pulseClear();
        pushClear();
        @(negedge clock);
        checkOutput("clear_busy_pending", clear_busy, 1'b1);
        repeat (40) @(posedge clock);
        pulseClear();
        waitDrain("merged_clear_drain");
        checkOutput("clear_busy_after_merge", clear_busy, 1'b0);

        // Randomised mix of loads, bursts, clears and idle gaps.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                applyStimulus(1'b0, 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                              3'($urandom_range(0, 7)), 1'b0, accA);
            end else if (op <= 7) begin
                nb = $urandom_range(1, 3);
                withLoad = 1'($urandom_range(0, 1));
                fork
                    begin
                        for (int b = 0; b < nb; b++) begin
                            applyStimulus(1'b1, 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                                          3'($urandom_range(0, 7)), b == nb - 1, accLast);
                        end
                    end
                    begin
                        if (withLoad) begin
                            repeat ($urandom_range(0, 20)) @(posedge clock);
                            applyStimulus(1'b0, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                                          3'($urandom_range(0, 7)), 1'b0, accB);
                        end
                    end
                join
            end else if (op == 8) begin
                waitDrain("random_pre_clear");
                pulseClear();
                pushClear();
            end else begin
                repeat ($urandom_range(1, 5)) @(posedge clock);
            end
        end
        waitDrain("random_drain");
        checkOutput("range_err_random", range_err, rangeErrExp);
        checkOutput("clear_busy_random", clear_busy, 1'b0);

        // Reset in the middle of a sim block, then the sweep on release.
        applyStimulus(1'b1, 8'd1, 8'd2, 3'd5, 1'b1, accA);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        expQ.delete();
        inGen = 1'b0;
        rangeErrExp = 1'b0;
        #1;
        checkOutput("midreset_vga_plot", vga_plot, 1'b0);
        checkOutput("midreset_load_ready", load_ready, 1'b0);
        checkOutput("midreset_sim_ready", sim_ready, 1'b0);
        checkOutput("midreset_gen_done", gen_done, 1'b0);
        checkOutput("midreset_range_err", range_err, 1'b0);
        checkOutput("midreset_clear_busy", clear_busy, 1'b1);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        pushClear();
        waitDrain("post_reset_clear_drain");
        checkOutput("clear_busy_final", clear_busy, 1'b0);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
